// File: rtl/sprite_lane_controller.sv
// ---------------------------------------------------------------------------
// sprite_lane_controller
//
// Purpose:
//   Moves NUM_LANES sprites right-to-left on a shared step timer. Hits from
//   the per-lane hit detectors respawn a sprite, add to a saturating BCD
//   score and shorten the step period. A sprite that reaches x=0 unhit is a
//   miss and costs a life. When the lives run out the game stops in OVER
//   until start is pressed again.
//
// Ports:
//   CLOCK_50   in   1                  system clock, rising edge
//   reset      in   1                  synchronous, active-high reset
//   start      in   1                  IDLE->RUN, OVER->reinit+RUN
//   hit        in   NUM_LANES          per-lane hit pulse
//   xoffset    out  NUM_LANES*X_W      lane i at [i*X_W +: X_W]
//   yoffset    out  NUM_LANES*Y_W      lane i at [i*Y_W +: Y_W] (constant)
//   step       out  1                  one-cycle pulse per movement step
//   score      out  4*SCORE_DIGITS     BCD score, digit 0 in [3:0]
//   lives      out  4                  remaining lives
//   game_over  out  1                  high in OVER
// ---------------------------------------------------------------------------
module sprite_lane_controller #(
    parameter int NUM_LANES    = 2,
    parameter int X_W          = 9,
    parameter int Y_W          = 8,
    parameter int X_START      = 160,
    parameter int LANE_GAP     = 40,
    parameter int LANE_Y_BASE  = 120,
    parameter int LANE_Y_STEP  = 20,
    parameter int DELAY_W      = 24,
    parameter int INIT_DELAY   = 5000000,
    parameter int DELAY_STEP   = 500000,
    parameter int MIN_DELAY    = 500000,
    parameter int SCORE_DIGITS = 2,
    parameter int LIVES        = 3
) (
    input  logic                        CLOCK_50,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_LANES-1:0]        hit,
    output logic [NUM_LANES*X_W-1:0]    xoffset,
    output logic [NUM_LANES*Y_W-1:0]    yoffset,
    output logic                        step,
    output logic [4*SCORE_DIGITS-1:0]   score,
    output logic [3:0]                  lives,
    output logic                        game_over
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OVER
    } state_t;

    // Extra headroom so popcount*DELAY_STEP + MIN_DELAY never overflows
    localparam int DW = DELAY_W + 4;

    state_t                    r_state;
    state_t                    w_stateNext;

    logic [X_W-1:0]            r_x [NUM_LANES];
    logic [4*SCORE_DIGITS-1:0] r_score;
    logic [3:0]                r_lives;
    logic                      r_gameOver;
    logic                      r_step;
    logic [DELAY_W-1:0]        r_curDelay;
    logic [DELAY_W-1:0]        r_delayCnt;

    logic                      w_run;
    logic                      w_tick;
    logic                      w_reinit;
    logic [NUM_LANES-1:0]      w_hitLane;
    logic [NUM_LANES-1:0]      w_missLane;
    logic [3:0]                w_hitCount;
    logic [3:0]                w_missCount;
    logic [4*SCORE_DIGITS-1:0] w_scoreNext;
    logic [4:0]                w_digitSum;
    logic [3:0]                w_carry;
    logic [DW-1:0]             w_delayDec;
    logic [DELAY_W-1:0]        w_curDelayNext;
    logic [3:0]                w_livesNext;

    assign w_run    = (r_state == S_RUN);
    assign w_tick   = w_run && (r_delayCnt == '0);
    assign w_reinit = (r_state == S_OVER) && start;

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic; the OVER->RUN restart reloads the datapath too
    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            S_IDLE:  if (start)          w_stateNext = S_RUN;
            S_RUN:   if (r_lives == '0)  w_stateNext = S_OVER;
            S_OVER:  if (start)          w_stateNext = S_RUN;
            default:                     w_stateNext = S_IDLE;
        endcase
    end

    // Per-lane hit/miss qualification. A hit masks a miss on the same lane.
    always_comb begin
        w_hitLane   = hit & {NUM_LANES{w_run}};
        w_missLane  = '0;
        w_hitCount  = '0;
        w_missCount = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_missLane[i] = w_tick && !w_hitLane[i] && (r_x[i] == '0);
            w_hitCount    = w_hitCount + 4'(w_hitLane[i]);
            w_missCount   = w_missCount + 4'(w_missLane[i]);
        end
    end

    // BCD add of the hit count, rippling a carry through the digits.
    // A carry out of the top digit means overflow, so pin at all nines.
    always_comb begin
        w_scoreNext = r_score;
        w_carry     = w_hitCount;
        w_digitSum  = '0;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            w_digitSum = {1'b0, r_score[d*4 +: 4]} + {1'b0, w_carry};
            if (w_digitSum >= 5'd10) begin
                w_scoreNext[d*4 +: 4] = 4'(w_digitSum - 5'd10);
                w_carry               = 4'd1;
            end else begin
                w_scoreNext[d*4 +: 4] = w_digitSum[3:0];
                w_carry               = 4'd0;
            end
        end
        if (w_carry != '0) begin
            w_scoreNext = {SCORE_DIGITS{4'h9}};
        end
    end

    // Speed-up: subtract in a wider domain so the floor check cannot underflow
    always_comb begin
        w_delayDec = DW'(w_hitCount) * DW'(DELAY_STEP);
        if ({4'b0, r_curDelay} >= (w_delayDec + DW'(MIN_DELAY))) begin
            w_curDelayNext = r_curDelay - w_delayDec[DELAY_W-1:0];
        end else begin
            w_curDelayNext = DELAY_W'(MIN_DELAY);
        end
    end

    // Lives saturate at zero when several lanes miss on one step
    always_comb begin
        if (r_lives > w_missCount) begin
            w_livesNext = r_lives - w_missCount;
        end else begin
            w_livesNext = '0;
        end
    end

    // Datapath: timer, sprite positions, score, lives and game_over.
    // Everything is frozen outside RUN.
    always_ff @(posedge CLOCK_50) begin
        if (reset || w_reinit) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                r_x[i] <= X_W'(X_START - i * LANE_GAP);
            end
            r_score    <= '0;
            r_lives    <= 4'(LIVES);
            r_gameOver <= 1'b0;
            r_step     <= 1'b0;
            r_curDelay <= DELAY_W'(INIT_DELAY);
            r_delayCnt <= DELAY_W'(INIT_DELAY);
        end else begin
            r_step <= 1'b0;
            if (w_run) begin
                // Reload uses the current delay, so a hit this cycle
                // only shortens the period from the following reload.
                if (w_tick) begin
                    r_step     <= 1'b1;
                    r_delayCnt <= r_curDelay;
                end else begin
                    r_delayCnt <= r_delayCnt - DELAY_W'(1);
                end

                for (int i = 0; i < NUM_LANES; i++) begin
                    if (w_hitLane[i] || w_missLane[i]) begin
                        r_x[i] <= X_W'(X_START);
                    end else if (w_tick) begin
                        r_x[i] <= r_x[i] - X_W'(1);
                    end
                end

                if (w_hitCount != '0) begin
                    r_score    <= w_scoreNext;
                    r_curDelay <= w_curDelayNext;
                end

                r_lives <= w_livesNext;

                // Leaving RUN for OVER on this edge
                if (r_lives == '0) begin
                    r_gameOver <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
        assign xoffset[g*X_W +: X_W] = r_x[g];
        assign yoffset[g*Y_W +: Y_W] = Y_W'(LANE_Y_BASE + g * LANE_Y_STEP);
    end

    assign step      = r_step;
    assign score     = r_score;
    assign lives     = r_lives;
    assign game_over = r_gameOver;

endmodule

// File: tb/tb_sprite_lane_controller.sv
// ---------------------------------------------------------------------------
// tb_sprite_lane_controller
//
// Purpose:
//   Directed self-checking bench for sprite_lane_controller with small
//   parameters (X_START=8, LANE_GAP=4, INIT_DELAY=3, DELAY_STEP=1,
//   MIN_DELAY=1, LIVES=2). Expected values are worked out by hand from the
//   intended behaviour.
// ---------------------------------------------------------------------------
module tb_sprite_lane_controller;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  hit;
    logic [17:0] xoffset;
    logic [15:0] yoffset;
    logic        step;
    logic [7:0]  score;
    logic [3:0]  lives;
    logic        gameOver;

    int testsRun    = 0;
    int testsFailed = 0;
    int stepCount;
    int cycles;

    sprite_lane_controller #(
        .NUM_LANES    (2),
        .X_W          (9),
        .Y_W          (8),
        .X_START      (8),
        .LANE_GAP     (4),
        .LANE_Y_BASE  (120),
        .LANE_Y_STEP  (20),
        .DELAY_W      (24),
        .INIT_DELAY   (3),
        .DELAY_STEP   (1),
        .MIN_DELAY    (1),
        .SCORE_DIGITS (2),
        .LIVES        (2)
    ) dut (
        .CLOCK_50  (clock),
        .reset     (reset),
        .start     (start),
        .hit       (hit),
        .xoffset   (xoffset),
        .yoffset   (yoffset),
        .step      (step),
        .score     (score),
        .lives     (lives),
        .game_over (gameOver)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance n clock edges, leaving time just past the last edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Drive hit/start for a number of cycles, then release them
    task automatic applyStimulus(input logic [1:0] hitVal, input logic startVal,
                                 input int n);
        hit   = hitVal;
        start = startVal;
        tick(n);
        hit   = 2'b00;
        start = 1'b0;
    endtask

    // Tick until step is seen (bounded); returns the number of edges taken
    task automatic waitStep(input string tag, output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!step && n < 20);
        checkOutput({tag, " stepSeen"}, 32'(step), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        hit   = 2'b00;
        tick(2);
        reset = 1'b0;
        tick(1);

        // Reset state
        checkOutput("reset x0",    32'(xoffset[8:0]),  32'd8);
        checkOutput("reset x1",    32'(xoffset[17:9]), 32'd4);
        checkOutput("reset y0",    32'(yoffset[7:0]),  32'd120);
        checkOutput("reset y1",    32'(yoffset[15:8]), 32'd140);
        checkOutput("reset score", 32'(score),         32'h00);
        checkOutput("reset lives", 32'(lives),         32'd2);
        checkOutput("reset over",  32'(gameOver),      32'd0);

        // Idle for 50 cycles: nothing moves
        stepCount = 0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (step) stepCount++;
        end
        checkOutput("idle steps", 32'(stepCount),     32'd0);
        checkOutput("idle x0",    32'(xoffset[8:0]),  32'd8);
        checkOutput("idle x1",    32'(xoffset[17:9]), 32'd4);

        // Start and run: step period is INIT_DELAY+1 = 4
        applyStimulus(2'b00, 1'b1, 1);
        waitStep("run1", cycles);
        checkOutput("first step latency", 32'(cycles), 32'd4);
        checkOutput("run1 x0", 32'(xoffset[8:0]),  32'd7);
        checkOutput("run1 x1", 32'(xoffset[17:9]), 32'd3);
        for (int s = 2; s <= 4; s++) begin
            waitStep("run", cycles);
            checkOutput("run period", 32'(cycles), 32'd4);
        end
        checkOutput("4 steps x0", 32'(xoffset[8:0]),  32'd4);
        checkOutput("4 steps x1", 32'(xoffset[17:9]), 32'd0);
        checkOutput("4 steps lives", 32'(lives), 32'd2);
        waitStep("run5", cycles);
        checkOutput("miss x1",    32'(xoffset[17:9]), 32'd8);
        checkOutput("miss x0",    32'(xoffset[8:0]),  32'd3);
        checkOutput("miss lives", 32'(lives),         32'd1);

        // Hits speed the step up: period 4 -> 3 -> 2 -> floor 2
        applyStimulus(2'b01, 1'b0, 1);
        checkOutput("hit1 x0",    32'(xoffset[8:0]), 32'd8);
        checkOutput("hit1 score", 32'(score),        32'h01);
        waitStep("hit1", cycles);
        checkOutput("hit1 transition", 32'(cycles), 32'd3);
        waitStep("hit1", cycles);
        checkOutput("hit1 period", 32'(cycles), 32'd3);

        applyStimulus(2'b01, 1'b0, 1);
        checkOutput("hit2 score", 32'(score), 32'h02);
        waitStep("hit2", cycles);
        checkOutput("hit2 transition", 32'(cycles), 32'd2);
        waitStep("hit2", cycles);
        checkOutput("hit2 period", 32'(cycles), 32'd2);

        applyStimulus(2'b01, 1'b0, 1);
        checkOutput("hit3 score", 32'(score), 32'h03);
        waitStep("hit3", cycles);
        checkOutput("hit3 transition", 32'(cycles), 32'd1);
        waitStep("hit3", cycles);
        checkOutput("floor period", 32'(cycles), 32'd2);
        checkOutput("six steps x1", 32'(xoffset[17:9]), 32'd2);

        // Hit on lane 1 in the very cycle it would miss at x=0
        waitStep("toZero", cycles);
        waitStep("toZero", cycles);
        checkOutput("x1 at zero", 32'(xoffset[17:9]), 32'd0);
        tick(1);
        applyStimulus(2'b10, 1'b0, 1);
        checkOutput("hitmiss step",  32'(step),           32'd1);
        checkOutput("hitmiss x1",    32'(xoffset[17:9]),  32'd8);
        checkOutput("hitmiss lives", 32'(lives),          32'd1);
        checkOutput("hitmiss score", 32'(score),          32'h04);

        // Double hits: BCD carry, then saturation at 99
        applyStimulus(2'b11, 1'b0, 3);
        checkOutput("bcd carry", 32'(score), 32'h10);
        applyStimulus(2'b11, 1'b0, 44);
        checkOutput("score 98", 32'(score), 32'h98);
        applyStimulus(2'b11, 1'b0, 1);
        checkOutput("score sat", 32'(score), 32'h99);
        applyStimulus(2'b11, 1'b0, 2);
        checkOutput("score hold", 32'(score), 32'h99);
        checkOutput("hits lives", 32'(lives), 32'd1);

        // No more hits: both lanes miss together, lives saturate at 0
        cycles = 0;
        while (!gameOver && cycles < 100) begin
            tick(1);
            cycles++;
        end
        checkOutput("game over", 32'(gameOver), 32'd1);
        checkOutput("over lives", 32'(lives), 32'd0);
        stepCount = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (step) stepCount++;
        end
        checkOutput("over steps", 32'(stepCount),     32'd0);
        checkOutput("over x0",    32'(xoffset[8:0]),  32'd8);
        checkOutput("over x1",    32'(xoffset[17:9]), 32'd8);
        checkOutput("over score", 32'(score),         32'h99);

        // Restart from OVER: init values and straight into RUN
        applyStimulus(2'b00, 1'b1, 1);
        checkOutput("restart x0",    32'(xoffset[8:0]),  32'd8);
        checkOutput("restart x1",    32'(xoffset[17:9]), 32'd4);
        checkOutput("restart score", 32'(score),         32'h00);
        checkOutput("restart lives", 32'(lives),         32'd2);
        checkOutput("restart over",  32'(gameOver),      32'd0);
        waitStep("restart", cycles);
        checkOutput("restart period", 32'(cycles), 32'd4);
        checkOutput("restart step x0", 32'(xoffset[8:0]), 32'd7);

        // Reset mid-RUN returns to IDLE with init values
        applyStimulus(2'b01, 1'b0, 1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        checkOutput("midreset x0",    32'(xoffset[8:0]),  32'd8);
        checkOutput("midreset x1",    32'(xoffset[17:9]), 32'd4);
        checkOutput("midreset score", 32'(score),         32'h00);
        checkOutput("midreset lives", 32'(lives),         32'd2);
        stepCount = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (step) stepCount++;
        end
        checkOutput("midreset idle", 32'(stepCount), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
